cmd_out_stream_arbiter: RTL

- Merges per-accelerator finish/command streams into the single TID-tagged stream consumed by the command-out writer.
- Round-robin arbitration at packet granularity. A granted accelerator holds the output until its TLAST beat is accepted, so header/task-id/parent-id words never interleave.
- Sits between the accelerator AXI-Stream outputs and the command-out block's inStream. It also provides a software-configurable enable mask and a per-requester packet counter for debug.

---
 rtl/cmd_out_stream_arbiter_pkg.sv | 12 +
 rtl/cmd_out_stream_arbiter_rr_priority_picker.sv | 34 +++
 rtl/cmd_out_stream_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cmd_out_stream_arbiter_pkg.sv
// Shared manager constants and the command-out arbiter state encoding.
package OmpSsManager;

  localparam int ACC_BITS = 4;
  localparam int MAX_ACCS = 16;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cmd_out_stream_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request strictly after `last`, wrapping.
// Built as a double-width masked priority encoder so any queue arbiter can reuse it.
module rr_priority_picker #(
  parameter int NUM_ACCS = OmpSsManager::MAX_ACCS,
  parameter int ACC_BITS = OmpSsManager::ACC_BITS
) (
  input  logic [NUM_ACCS-1:0] req,
  input  logic [ACC_BITS-1:0] last,
  output logic [ACC_BITS-1:0] gnt_idx,
  output logic                gnt_valid
);

  logic [2*NUM_ACCS-1:0] req_dbl;
  int                    start_pos;

  // NOTE: every output of a combinational block gets a default first, otherwise
  // any path that skips an assignment infers a latch.
  always_comb begin
    req_dbl   = {req, req};
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    start_pos = int'(last) + 1;
    if (start_pos >= NUM_ACCS) start_pos = 0;
    // Lower copy is masked below start_pos; the upper copy supplies the wrap.
    // Scanning downward leaves the lowest surviving position in gnt_idx.
    for (int j = 2*NUM_ACCS-1; j >= 0; j--) begin
      if (req_dbl[j] && (j >= start_pos)) begin
        gnt_valid = 1'b1;
        gnt_idx   = ACC_BITS'(j % NUM_ACCS);
      end
    end
  end

endmodule

// File: rtl/cmd_out_stream_arbiter.sv
// Packet-granular round-robin merge of accelerator command streams into one
// TID-tagged stream, with an enable mask and per-requester packet counters.
module cmd_out_stream_arbiter
  import OmpSsManager::*;
#(
  parameter int NUM_ACCS = 16,
  parameter int ACC_BITS = 4,
  parameter int DATA_W   = 64,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_ACCS*DATA_W-1:0] acc_TDATA,
  input  logic [NUM_ACCS-1:0]        acc_TVALID,
  input  logic [NUM_ACCS-1:0]        acc_TLAST,
  output logic [NUM_ACCS-1:0]        acc_TREADY,
  input  logic [NUM_ACCS-1:0]        acc_enable,
  output logic [DATA_W-1:0]          outStream_TDATA,
  output logic                       outStream_TVALID,
  output logic [3:0]                 outStream_TID,
  output logic                       outStream_TLAST,
  input  logic                       outStream_TREADY,
  input  logic [ACC_BITS-1:0]        cnt_sel,
  output logic [CNT_W-1:0]           cnt_value,
  output logic                       busy
);

  arb_state_e          state_q, state_d;
  logic [ACC_BITS-1:0] grant_q, last_grant_q, pick_idx;
  logic                pick_valid;
  logic [NUM_ACCS-1:0] req;
  logic                out_ready, xfer_hs, xfer_last;

  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q, out_last_q;
  logic [ACC_BITS-1:0] out_tid_q;
  logic [CNT_W-1:0]    cnt_q [NUM_ACCS];

  // The mask only matters here, so it is effectively sampled in ARB alone.
  assign req = acc_TVALID & acc_enable;

  rr_priority_picker #(
    .NUM_ACCS (NUM_ACCS),
    .ACC_BITS (ACC_BITS)
  ) u_picker (
    .req       (req),
    .last      (last_grant_q),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  assign out_ready = !out_valid_q || outStream_TREADY;
  assign xfer_hs   = (state_q == XFER) && acc_TVALID[grant_q] && out_ready;
  assign xfer_last = xfer_hs && acc_TLAST[grant_q];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ARB;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (pick_valid) state_d = XFER;
      XFER:    if (xfer_last)  state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    acc_TREADY = '0;
    busy       = 1'b0;
    if (state_q == XFER) begin
      acc_TREADY[grant_q] = out_ready;
      busy                = 1'b1;
    end
  end

  // last_grant starts at the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_q      <= '0;
      last_grant_q <= ACC_BITS'(NUM_ACCS-1);
    end else begin
      if ((state_q == ARB) && pick_valid) grant_q <= pick_idx;
      if (xfer_last) last_grant_q <= grant_q;
    end
  end

  // One-entry slice: holds while stalled, reloads on the same edge it drains.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_tid_q   <= '0;
    end else if (xfer_hs) begin
      out_valid_q <= 1'b1;
      out_data_q  <= acc_TDATA[int'(grant_q)*DATA_W +: DATA_W];
      out_last_q  <= acc_TLAST[grant_q];
      out_tid_q   <= grant_q;
    end else if (outStream_TREADY) begin
      out_valid_q <= 1'b0;
    end
  end

  // NOTE: the counter array is small debug state that must read zero after
  // reset, so unlike a RAM it is reset explicitly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_ACCS; i++) cnt_q[i] <= '0;
    end else if (xfer_last && (cnt_q[grant_q] != '1)) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
    end
  end

  assign cnt_value = (int'(cnt_sel) < NUM_ACCS) ? cnt_q[cnt_sel] : '0;

  assign outStream_TDATA  = out_data_q;
  assign outStream_TVALID = out_valid_q;
  assign outStream_TLAST  = out_last_q;
  assign outStream_TID    = 4'(out_tid_q);

endmodule
